// File: rtl/axis_stream_checker_if.sv
// AXI-Stream beat bundle between a traffic source (master) and the stream checker (slave).
interface axis_stream_checker_if #(
    parameter int DSIZE = 16
);
    logic [DSIZE-1:0] axis_tdata;
    logic             axis_tvalid;
    logic             axis_tlast;
    logic             axis_tready;

    modport master (output axis_tdata, axis_tvalid, axis_tlast, input axis_tready);
    modport slave  (input axis_tdata, axis_tvalid, axis_tlast, output axis_tready);
endinterface

// File: rtl/axis_stream_checker.sv
// Checks frames of an AXI-Stream against a repeating pattern RAM and counts data/length errors.
// Compare happens on the accepting cycle; tready is registered and gated by an LFSR for random backpressure.
module axis_stream_checker #(
    parameter int DSIZE  = 16,
    parameter int PDEPTH = 16,
    parameter int LW     = 16,
    localparam int AW    = $clog2(PDEPTH)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 aclken,
    axis_stream_checker_if.slave s_axis,
    input  logic                 start,
    input  logic [LW-1:0]        num_frames,
    input  logic [LW-1:0]        exp_len,
    input  logic [AW:0]          pat_len,
    input  logic                 pat_we,
    input  logic [AW-1:0]        pat_addr,
    input  logic [DSIZE-1:0]     pat_wdata,
    input  logic [7:0]           ready_thresh,
    output logic                 busy,
    output logic                 done,
    output logic                 frame_done,
    output logic                 err,
    output logic [LW-1:0]        frame_cnt,
    output logic [LW-1:0]        data_err_cnt,
    output logic [LW-1:0]        len_err_cnt,
    output logic [LW-1:0]        beat_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic              tready_q, tready_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [LW-1:0]     frame_cnt_q, frame_cnt_d;
    logic [LW-1:0]     data_err_q, data_err_d;
    logic [LW-1:0]     len_err_q, len_err_d;
    logic [LW-1:0]     beat_idx_q, beat_idx_d;
    logic [AW-1:0]     pat_idx_q, pat_idx_d;
    logic              miss_q, miss_d;
    logic              err_q, err_d;
    logic              frame_done_q, frame_done_d;

    logic [DSIZE-1:0]  pat_mem [PDEPTH];
    logic [DSIZE-1:0]  exp_dat;
    logic [AW:0]       pat_nxt;
    logic              acc;
    logic              len_hit;

    function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
        return (&v) ? v : v + LW'(1);
    endfunction

    // Unreset RAM; the compare reads combinationally so a same-cycle write is seen only afterwards.
    always_ff @(posedge aclk) begin
        if (pat_we) pat_mem[pat_addr] <= pat_wdata;
    end

    assign exp_dat = pat_mem[pat_idx_q];
    assign acc     = s_axis.axis_tvalid & tready_q & aclken & (state_q == RUN);
    assign pat_nxt = {1'b0, pat_idx_q} + (AW+1)'(1);

    always_comb begin
        state_d      = state_q;
        tready_d     = tready_q;
        lfsr_d       = lfsr_q;
        frame_cnt_d  = frame_cnt_q;
        data_err_d   = data_err_q;
        len_err_d    = len_err_q;
        beat_idx_d   = beat_idx_q;
        pat_idx_d    = pat_idx_q;
        miss_d       = miss_q;
        err_d        = err_q;
        frame_done_d = 1'b0;
        len_hit      = 1'b0;
        if (aclken) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            if (start) begin
                state_d     = RUN;
                frame_cnt_d = '0;
                data_err_d  = '0;
                len_err_d   = '0;
                beat_idx_d  = '0;
                pat_idx_d   = '0;
                miss_d      = 1'b0;
                err_d       = 1'b0;
            end else if (acc) begin
                if (s_axis.axis_tdata != exp_dat) begin
                    data_err_d = sat_inc(data_err_q);
                    err_d      = 1'b1;
                end
                if (s_axis.axis_tlast) begin
                    len_hit      = (beat_idx_q < exp_len - LW'(1));
                    beat_idx_d   = '0;
                    pat_idx_d    = '0;
                    miss_d       = 1'b0;
                    frame_cnt_d  = sat_inc(frame_cnt_q);
                    frame_done_d = 1'b1;
                    if ((num_frames != '0) && (frame_cnt_d == num_frames)) state_d = DONE;
                end else begin
                    // A frame overrunning its length is flagged once, then runs on until tlast.
                    if ((beat_idx_q == exp_len - LW'(1)) && !miss_q) begin
                        len_hit = 1'b1;
                        miss_d  = 1'b1;
                    end
                    beat_idx_d = sat_inc(beat_idx_q);
                    pat_idx_d  = (pat_nxt >= pat_len) ? '0 : pat_nxt[AW-1:0];
                end
                if (len_hit) begin
                    len_err_d = sat_inc(len_err_q);
                    err_d     = 1'b1;
                end
            end
            // Ready stays low on the entry cycle into RUN and whenever RUN is being left.
            tready_d = (state_q == RUN) && (state_d == RUN) &&
                       ((ready_thresh == 8'hFF) || (lfsr_q[7:0] < ready_thresh));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            tready_q     <= 1'b0;
            lfsr_q       <= 16'hACE1;
            frame_cnt_q  <= '0;
            data_err_q   <= '0;
            len_err_q    <= '0;
            beat_idx_q   <= '0;
            pat_idx_q    <= '0;
            miss_q       <= 1'b0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tready_q     <= tready_d;
            lfsr_q       <= lfsr_d;
            frame_cnt_q  <= frame_cnt_d;
            data_err_q   <= data_err_d;
            len_err_q    <= len_err_d;
            beat_idx_q   <= beat_idx_d;
            pat_idx_q    <= pat_idx_d;
            miss_q       <= miss_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s_axis.axis_tready = tready_q;
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign frame_done   = frame_done_q;
    assign err          = err_q;
    assign frame_cnt    = frame_cnt_q;
    assign data_err_cnt = data_err_q;
    assign len_err_cnt  = len_err_q;
    assign beat_idx     = beat_idx_q;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed bench for axis_stream_checker: clean/corrupt/length-error frames, random backpressure,
// clock-enable toggling, mid-frame reset and same-cycle pattern write.
module tb_axis_stream_checker;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        aclken;
    logic        start;
    logic [15:0] num_frames;
    logic [15:0] exp_len;
    logic [4:0]  pat_len;
    logic        pat_we;
    logic [3:0]  pat_addr;
    logic [15:0] pat_wdata;
    logic [7:0]  ready_thresh;
    logic        busy, done, frame_done, err;
    logic [15:0] frame_cnt, data_err_cnt, len_err_cnt, beat_idx;

    axis_stream_checker_if #(.DSIZE(16)) s_if ();

    axis_stream_checker #(.DSIZE(16), .PDEPTH(16), .LW(16)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .aclken       (aclken),
        .s_axis       (s_if),
        .start        (start),
        .num_frames   (num_frames),
        .exp_len      (exp_len),
        .pat_len      (pat_len),
        .pat_we       (pat_we),
        .pat_addr     (pat_addr),
        .pat_wdata    (pat_wdata),
        .ready_thresh (ready_thresh),
        .busy         (busy),
        .done         (done),
        .frame_done   (frame_done),
        .err          (err),
        .frame_cnt    (frame_cnt),
        .data_err_cnt (data_err_cnt),
        .len_err_cnt  (len_err_cnt),
        .beat_idx     (beat_idx)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ready_cyc;
    int          total_cyc;
    int          wr_beat = -1;
    bit          wr_pend;
    bit          en_toggle;
    logic [15:0] pat_m [4];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_pat(input logic [3:0] a, input logic [15:0] d);
        pat_we = 1'b1; pat_addr = a; pat_wdata = d;
        tick();
        pat_we = 1'b0;
    endtask

    task automatic pulse_start();
        aclken = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Holds a beat until accepted; while tready is low a bogus tlast beat is offered instead.
    task automatic send_beat(input logic [15:0] d, input logic last);
        bit sent = 0;
        int n    = 0;
        while (!sent && n < 200) begin
            if (en_toggle) aclken = ~aclken;
            if (s_if.axis_tready) begin
                s_if.axis_tvalid = 1'b1; s_if.axis_tdata = d;  s_if.axis_tlast = last;
            end else begin
                s_if.axis_tvalid = 1'b1; s_if.axis_tdata = ~d; s_if.axis_tlast = 1'b1;
            end
            if (aclken) begin
                total_cyc++;
                if (s_if.axis_tready) ready_cyc++;
            end
            sent = s_if.axis_tready && aclken;
            if (sent && wr_pend) begin
                pat_we = 1'b1; pat_addr = 4'd0; pat_wdata = 16'h5555;
            end
            tick();
            pat_we = 1'b0;
            n++;
        end
        s_if.axis_tvalid = 1'b0;
        s_if.axis_tlast  = 1'b0;
        if (!sent) chk_eq("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int n, input int bad);
        for (int i = 0; i < n; i++) begin
            logic [15:0] d;
            d = pat_m[i % 4];
            if (i == bad) d = d ^ 16'h00F0;
            wr_pend = (i == wr_beat);
            send_beat(d, i == n - 1);
        end
        wr_pend = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk_eq({tag, "_tready"}, s_if.axis_tready, 0);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_done"}, done, 0);
        chk_eq({tag, "_fdone"}, frame_done, 0);
        chk_eq({tag, "_err"}, err, 0);
        chk_eq({tag, "_frames"}, frame_cnt, 0);
        chk_eq({tag, "_derr"}, data_err_cnt, 0);
        chk_eq({tag, "_lerr"}, len_err_cnt, 0);
        chk_eq({tag, "_bidx"}, beat_idx, 0);
    endtask

    task automatic check_stats(input string tag, input int fr, input int de, input int le,
                               input int e, input int dn);
        chk_eq({tag, "_frames"}, frame_cnt, fr);
        chk_eq({tag, "_derr"}, data_err_cnt, de);
        chk_eq({tag, "_lerr"}, len_err_cnt, le);
        chk_eq({tag, "_err"}, err, e);
        chk_eq({tag, "_done"}, done, dn);
        chk_eq({tag, "_bidx"}, beat_idx, 0);
    endtask

    initial begin
        int pct;
        aresetn = 1'b0; aclken = 1'b1; start = 1'b0;
        num_frames = 16'd2; exp_len = 16'd8; pat_len = 5'd4; ready_thresh = 8'hFF;
        pat_we = 1'b0; pat_addr = '0; pat_wdata = '0;
        s_if.axis_tvalid = 1'b0; s_if.axis_tlast = 1'b0; s_if.axis_tdata = '0;
        en_toggle = 0; wr_pend = 0; ready_cyc = 0; total_cyc = 0;
        for (int i = 0; i < 4; i++) pat_m[i] = 16'(i);

        repeat (3) tick();
        check_reset("rst0");
        aresetn = 1'b1;
        tick(); tick();
        chk_eq("rst0_tready_idle", s_if.axis_tready, 0);
        for (int i = 0; i < 4; i++) write_pat(4'(i), pat_m[i]);

        // Two clean 8-beat frames
        pulse_start();
        chk_eq("t1_tready_entry", s_if.axis_tready, 0);
        chk_eq("t1_busy", busy, 1);
        send_frame(8, -1);
        send_frame(8, -1);
        chk_eq("t1_fdone_pulse", frame_done, 1);
        chk_eq("t1_tready_done", s_if.axis_tready, 0);
        check_stats("t1", 2, 0, 0, 0, 1);
        tick();
        chk_eq("t1_fdone_clear", frame_done, 0);

        // Beat 5 of the first frame corrupted
        pulse_start();
        send_frame(8, 5);
        send_frame(8, -1);
        check_stats("t2", 2, 1, 0, 1, 1);

        // Early last at beat 5, then an overlong 10-beat frame
        pulse_start();
        send_frame(6, -1);
        send_frame(10, -1);
        check_stats("t3", 2, 0, 2, 1, 1);

        // Random backpressure, unbounded run of 125 frames = 1000 beats
        num_frames = 16'd0; ready_thresh = 8'h80;
        pulse_start();
        ready_cyc = 0; total_cyc = 0;
        repeat (125) send_frame(8, -1);
        check_stats("t4", 125, 0, 0, 0, 0);
        chk_eq("t4_busy", busy, 1);
        pct = ready_cyc * 100 / total_cyc;
        chk_eq("t4_duty_40_60", (pct >= 40 && pct <= 60), 1);

        // Restart mid-frame from RUN, then toggle aclken through a corrupted run
        for (int i = 0; i < 3; i++) send_beat(pat_m[i], 1'b0);
        chk_eq("t5_bidx_mid", beat_idx, 3);
        num_frames = 16'd2; ready_thresh = 8'hFF;
        pulse_start();
        chk_eq("t5_busy_restart", busy, 1);
        chk_eq("t5_bidx_restart", beat_idx, 0);
        en_toggle = 1;
        send_frame(8, 5);
        send_frame(8, -1);
        en_toggle = 0; aclken = 1'b1;
        check_stats("t5", 2, 1, 0, 1, 1);

        // Reset after beat 3 of a frame
        num_frames = 16'd1;
        pulse_start();
        for (int i = 0; i < 4; i++) send_beat(pat_m[i], 1'b0);
        aresetn = 1'b0;
        #2;
        check_reset("t6_rst");
        tick(); tick();
        aresetn = 1'b1;
        repeat (3) tick();
        chk_eq("t6_tready_nostart", s_if.axis_tready, 0);
        chk_eq("t6_busy_nostart", busy, 0);
        // Overwrite pattern[0] on the cycle beat 4 reads it: that compare must see the old value
        pulse_start();
        wr_beat = 4;
        send_frame(8, -1);
        wr_beat = -1;
        check_stats("t6", 1, 0, 0, 0, 1);

        // Now pattern[0] = 5555, so beats 0 and 4 mismatch
        pulse_start();
        send_frame(8, -1);
        check_stats("t7", 1, 2, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_stream_checker.md
AXIS_STREAM_CHECKER -- requirements
Module: axis_stream_checker

Interface
REQ-001 SHALL have parameter DSIZE, default 16, meaning the tdata width in bits.
REQ-002 SHALL have parameter PDEPTH, default 16, meaning the number of expected-pattern entries (power of 2).
REQ-003 SHALL have parameter LW, default 16, meaning the width of length and counter fields.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports listed below.
REQ-005 aclk  in  1  clock.
REQ-006 aresetn  in  1  asynchronous active-low reset.
REQ-007 aclken  in  1  clock enable; a beat transfers only when tvalid, tready and aclken are all 1.
REQ-008 axis_tdata  in  DSIZE  stream data.
REQ-009 axis_tvalid  in  1  stream valid.
REQ-010 axis_tlast  in  1  end of frame.
REQ-011 axis_tready  out  1  registered backpressure.
REQ-012 start  in  1  one-cycle pulse that clears statistics and begins a run.
REQ-013 num_frames  in  LW  frames per run; 0 means unbounded.
REQ-014 exp_len  in  LW  expected beats per frame, 1 or more.
REQ-015 pat_len  in  $clog2(PDEPTH)+1  active pattern entries, 1..PDEPTH.
REQ-016 pat_we / pat_addr / pat_wdata  in  1 / $clog2(PDEPTH) / DSIZE  pattern RAM write port.
REQ-017 ready_thresh  in  8  ready probability; 8'hFF means always ready.
REQ-018 busy, done, frame_done, err  out  1 each  status; frame_done is a one-cycle pulse and err is sticky.
REQ-019 frame_cnt, data_err_cnt, len_err_cnt, beat_idx  out  LW each  statistics.

Function
REQ-020 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-021 IDLE SHALL go to RUN on start; DONE SHALL go to RUN on start; no other state transition is caused by start.
REQ-022 start SHALL, in the same cycle, zero frame_cnt, data_err_cnt, len_err_cnt, beat_idx and err.
REQ-023 RUN SHALL go to DONE on the accepted tlast beat that makes frame_cnt equal num_frames (num_frames != 0).
REQ-024 axis_tready SHALL be 0 in IDLE and DONE, and in the cycle the FSM enters RUN.
REQ-025 In RUN, axis_tready for the next cycle SHALL be 1 when ready_thresh == 8'hFF or lfsr[7:0] < ready_thresh.
REQ-026 The LFSR SHALL be 16-bit, x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing every aclk cycle with aclken = 1.
REQ-027 When aclken = 0, state, counters, LFSR and axis_tready SHALL hold.
REQ-028 On an accepted beat, the expected data SHALL be pattern[beat_idx mod pat_len]; a mismatch SHALL increment data_err_cnt and set err.
REQ-029 beat_idx SHALL increment on each accepted beat and return to 0 on an accepted tlast beat.
REQ-030 Early last (tlast with beat_idx < exp_len-1) SHALL count as one length error.
REQ-031 Missing last (beat_idx == exp_len-1 without tlast) SHALL count as one length error, once per frame; the frame continues until tlast.
REQ-032 Each length error SHALL increment len_err_cnt and set err.
REQ-033 On an accepted tlast beat, frame_cnt SHALL increment and frame_done SHALL pulse for 1 cycle with 1-cycle latency.
REQ-034 All counters SHALL saturate at all-ones and never wrap.
REQ-035 A pattern write in the same cycle as a compare read of that address SHALL compare against the old value.
REQ-036 start in RUN SHALL clear statistics and stay in RUN; beat_idx SHALL restart at 0 even mid-frame.
REQ-037 busy SHALL equal (state == RUN) and done SHALL equal (state == DONE).
REQ-038 Beats presented while axis_tready = 0 SHALL be ignored and not counted.

Reset
REQ-039 While aresetn = 0, the block SHALL be in IDLE with axis_tready = 0, busy = 0, done = 0, frame_done = 0, err = 0, all counters = 0 and LFSR = 16'hACE1.
REQ-040 Reset asserted mid-frame SHALL abandon the frame immediately.
REQ-041 After reset release, the block SHALL require a new start before axis_tready rises.
REQ-042 The pattern RAM SHALL not be reset.

Verification
REQ-043 Pattern 0..3, pat_len = 4, exp_len = 8, num_frames = 2, ready_thresh = FF, 16 clean beats -> frame_cnt = 2, done = 1, err = 0, tready = 0 after the second tlast.
REQ-044 Same setup with beat 5 data corrupted -> data_err_cnt = 1, err = 1, len_err_cnt = 0.
REQ-045 exp_len = 8 with tlast on beat 5, then a 10-beat frame -> len_err_cnt = 2, frame_cnt = 2.
REQ-046 ready_thresh = 0x80, 1000 beats -> tready duty cycle 40-60 %, all beats checked, no errors, and no transfer counted while tready = 0.
REQ-047 aclken toggled 50 % during a frame -> counters identical to the aclken = 1 run.
REQ-048 aresetn pulsed mid-frame after beat 3 -> all outputs at reset values; start plus a full frame gives frame_cnt = 1 and err = 0.
